// File: rtl/id_exe_skid_pkg.sv
// Shared decode/execute definitions: word and register-index widths, ALU commands,
// the decoded-op payload carried across the ID/EXE boundary, and the skid occupancy states.
package id_exe_skid_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;

  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_ADD,
    EXE_SUB,
    EXE_AND,
    EXE_OR,
    EXE_NOR,
    EXE_XOR,
    EXE_SLL,
    EXE_SRA,
    EXE_SRL,
    EXE_MOV,
    EXE_MVN
  } execmd_t;

  typedef struct packed {
    logic [WORD_LEN-1:0]          val1;
    logic [WORD_LEN-1:0]          val2;
    execmd_t                      exe_cmd;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic                         wb_en;
    logic                         mem_r_en;
    logic                         mem_w_en;
    logic [WORD_LEN-1:0]          st_val;
  } id_exe_payload_t;

  // Occupancy of the main/skid pair: EMPTY, main only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/id_exe_skid_if.sv
// Valid/ready channel carrying one decoded op; master drives the op, slave returns ready.
interface id_exe_skid_if
  import id_exe_skid_pkg::*;
#(
  parameter int DATA_W = WORD_LEN,
  parameter int DEST_W = REG_FILE_ADDR_LEN
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  execmd_t           exe_cmd;
  logic [DEST_W-1:0] dest;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] st_val;

  modport master (
    output valid, val1, val2, exe_cmd, dest, wb_en, mem_r_en, mem_w_en, st_val,
    input  ready
  );

  modport slave (
    input  valid, val1, val2, exe_cmd, dest, wb_en, mem_r_en, mem_w_en, st_val,
    output ready
  );

endinterface

// File: rtl/id_exe_skid_pipe_slot.sv
// One pipeline slot: a payload register with its valid bit. clear beats load;
// clear drops only the valid bit so the payload keeps its last value.
module id_exe_skid_pipe_slot #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  T     d,
  output logic valid,
  output T     q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  // NOTE: the payload is reset alongside the valid bit so the outputs read
  // all-zero after reset rather than power-up garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_exe_skid.sv
// Decode-to-execute boundary with a 2-entry skid buffer and registered in_ready.
// Optional stall counter on out_valid & !out_ready: define ID_EXE_STALL_CNT_EN.
module id_exe_skid
  import id_exe_skid_pkg::*;
#(
  parameter int DATA_W = WORD_LEN,
  parameter int DEST_W = REG_FILE_ADDR_LEN
`ifdef ID_EXE_STALL_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  id_exe_skid_if.slave        in_if,
  id_exe_skid_if.master       out_if
`ifdef ID_EXE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    execmd_t           exe_cmd;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] st_val;
  } payload_t;

  skid_state_t state, state_n;

  payload_t in_pl, main_d, main_q, skid_q;
  logic     main_valid, skid_valid;
  logic     main_load, main_from_skid, main_drop;
  logic     skid_load, skid_drop;
  logic     in_fire, out_fire;

  assign in_pl = '{
    val1:     in_if.val1,
    val2:     in_if.val2,
    exe_cmd:  in_if.exe_cmd,
    dest:     in_if.dest,
    wb_en:    in_if.wb_en,
    mem_r_en: in_if.mem_r_en,
    mem_w_en: in_if.mem_w_en,
    st_val:   in_if.st_val
  };

  // skid_valid is itself a flop, so in_ready never sees out_ready combinationally.
  assign in_if.ready = ~skid_valid;
  assign in_fire     = in_if.valid & ~skid_valid;
  assign out_fire    = main_valid & out_if.ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_n;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_n        = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;

    unique case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_n   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_n   = ST_FULL;
        end else if (out_fire) begin
          main_drop = 1'b1;
          state_n   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
          state_n        = ST_ONE;
        end
      end
      default: state_n = ST_EMPTY;
    endcase

    // A redirect discards everything, including an op accepted this same cycle.
    if (flush) begin
      state_n        = ST_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      main_drop      = 1'b1;
      skid_drop      = 1'b1;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  id_exe_skid_pipe_slot #(.T(payload_t)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  id_exe_skid_pipe_slot #(.T(payload_t)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_drop),
    .d     (in_pl),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign out_if.valid    = main_valid;
  assign out_if.val1     = main_q.val1;
  assign out_if.val2     = main_q.val2;
  assign out_if.exe_cmd  = main_q.exe_cmd;
  assign out_if.dest     = main_q.dest;
  assign out_if.st_val   = main_q.st_val;
  // Side-effecting controls are masked so a bubble can never write back or touch memory.
  assign out_if.wb_en    = main_q.wb_en    & main_valid;
  assign out_if.mem_r_en = main_q.mem_r_en & main_valid;
  assign out_if.mem_w_en = main_q.mem_w_en & main_valid;

`ifdef ID_EXE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           stall_cnt <= '0;
    else if (main_valid && !out_if.ready) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_id_exe_skid.sv
// Self-checking bench for id_exe_skid: a 2-deep FIFO model compared every cycle,
// plus directed vectors with literal expectations.
module tb_id_exe_skid;
  import id_exe_skid_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  id_exe_skid_if #(.DATA_W(WORD_LEN), .DEST_W(REG_FILE_ADDR_LEN)) in_if ();
  id_exe_skid_if #(.DATA_W(WORD_LEN), .DEST_W(REG_FILE_ADDR_LEN)) out_if ();

`ifdef ID_EXE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_exe_skid #(.DATA_W(WORD_LEN), .DEST_W(REG_FILE_ADDR_LEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if)
`ifdef ID_EXE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffer is a FIFO of capacity two; ready means room for one more.
  id_exe_payload_t mq[$];
  int unsigned     m_stall = 0;
  bit              live    = 1'b0;

  always @(posedge clk) begin
    id_exe_payload_t ip;
    bit m_rdy, m_ov;
    m_rdy = (mq.size() < 2);
    m_ov  = (mq.size() > 0);
    ip = '{val1: in_if.val1, val2: in_if.val2, exe_cmd: in_if.exe_cmd, dest: in_if.dest,
           wb_en: in_if.wb_en, mem_r_en: in_if.mem_r_en, mem_w_en: in_if.mem_w_en,
           st_val: in_if.st_val};
    live = 1'b1;
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (m_ov && !out_if.ready) m_stall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ov && out_if.ready) void'(mq.pop_front());
        if (in_if.valid && m_rdy) mq.push_back(ip);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      id_exe_payload_t obs;
      obs = '{val1: out_if.val1, val2: out_if.val2, exe_cmd: out_if.exe_cmd, dest: out_if.dest,
              wb_en: out_if.wb_en, mem_r_en: out_if.mem_r_en, mem_w_en: out_if.mem_w_en,
              st_val: out_if.st_val};
      check("model_in_ready", in_if.ready, mq.size() < 2);
      check("model_out_valid", out_if.valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("model_payload", obs, mq[0]);
      end else begin
        check("model_bubble_ctrl", {out_if.wb_en, out_if.mem_r_en, out_if.mem_w_en}, 3'b000);
      end
`ifdef ID_EXE_STALL_CNT_EN
      check("model_stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  task automatic drive(input bit v, input logic [31:0] v1, input logic [31:0] v2,
                       input execmd_t c, input logic [4:0] d,
                       input bit wb, input bit mr, input bit mw, input logic [31:0] st);
    in_if.valid    = v;
    in_if.val1     = v1;
    in_if.val2     = v2;
    in_if.exe_cmd  = c;
    in_if.dest     = d;
    in_if.wb_en    = wb;
    in_if.mem_r_en = mr;
    in_if.mem_w_en = mw;
    in_if.st_val   = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_if.ready = 1'b1;
    drive(1'b1, 32'hdead, 32'hbeef, EXE_SUB, 5'd7, 1'b1, 1'b1, 1'b1, 32'hcafe);

    // Reset held two cycles while decode offers an op.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_in_ready", in_if.ready, 1'b1);
    check("rst_val1", out_if.val1, 32'h0);
    check("rst_val2", out_if.val2, 32'h0);
    check("rst_st_val", out_if.st_val, 32'h0);
    check("rst_dest", out_if.dest, 5'd0);
    check("rst_cmd", out_if.exe_cmd, 4'd0);
    check("rst_ctrl", {out_if.wb_en, out_if.mem_r_en, out_if.mem_w_en}, 3'b000);

    // Streaming: one op per cycle, visible one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 2 * i, EXE_ADD, i[4:0], 1'b1, 1'b0, 1'b0, 32'h100 + i);
      tick();
      check("stream_val1", out_if.val1, i);
      check("stream_val2", out_if.val2, 2 * i);
      check("stream_valid", out_if.valid, 1'b1);
      check("stream_in_ready", in_if.ready, 1'b1);
    end
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    tick();
    check("stream_drained", out_if.valid, 1'b0);

    // Backpressure fills the skid; release drains in order.
    out_if.ready = 1'b0;
    drive(1'b1, 32'h11, 32'h1, EXE_AND, 5'd1, 1'b1, 1'b0, 1'b0, 0);
    tick();
    check("bp_a_val1", out_if.val1, 32'h11);
    check("bp_a_in_ready", in_if.ready, 1'b1);
    drive(1'b1, 32'h22, 32'h2, EXE_OR, 5'd2, 1'b1, 1'b0, 1'b0, 0);
    tick();
    check("bp_full_in_ready", in_if.ready, 1'b0);
    check("bp_hold_val1", out_if.val1, 32'h11);
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    tick();
    check("bp_hold2_val1", out_if.val1, 32'h11);
    check("bp_hold2_in_ready", in_if.ready, 1'b0);
    out_if.ready = 1'b1;
    tick();
    check("bp_b_val1", out_if.val1, 32'h22);
    check("bp_b_valid", out_if.valid, 1'b1);
    check("bp_b_in_ready", in_if.ready, 1'b1);
    tick();
    check("bp_empty", out_if.valid, 1'b0);

    // Flush while FULL with decode offering an op.
    out_if.ready = 1'b0;
    drive(1'b1, 32'h33, 0, EXE_XOR, 5'd3, 1'b1, 1'b0, 1'b1, 32'h3);
    tick();
    drive(1'b1, 32'h44, 0, EXE_SLL, 5'd4, 1'b1, 1'b0, 1'b1, 32'h4);
    tick();
    check("fl_full_in_ready", in_if.ready, 1'b0);
    drive(1'b1, 32'h55, 0, EXE_MOV, 5'd5, 1'b1, 1'b0, 1'b1, 32'h5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    check("fl_out_valid", out_if.valid, 1'b0);
    check("fl_in_ready", in_if.ready, 1'b1);
    check("fl_wb_en", out_if.wb_en, 1'b0);
    check("fl_mem_w_en", out_if.mem_w_en, 1'b0);
    out_if.ready = 1'b1;
    repeat (3) begin
      tick();
      check("fl_stays_empty", out_if.valid, 1'b0);
    end

    // Flush in ONE discards the op accepted in the same cycle.
    out_if.ready = 1'b0;
    drive(1'b1, 32'h66, 0, EXE_SRA, 5'd6, 1'b0, 1'b1, 1'b0, 0);
    tick();
    drive(1'b1, 32'h77, 0, EXE_SRL, 5'd7, 1'b0, 1'b1, 1'b0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    check("fl1_out_valid", out_if.valid, 1'b0);
    check("fl1_in_ready", in_if.ready, 1'b1);
    out_if.ready = 1'b1;
    tick();
    check("fl1_no_ghost", out_if.valid, 1'b0);

    // Bubble masking of control bits.
    drive(1'b1, 32'h88, 0, EXE_MVN, 5'd8, 1'b1, 1'b1, 1'b0, 0);
    tick();
    check("bub_wb_on", out_if.wb_en, 1'b1);
    check("bub_mr_on", out_if.mem_r_en, 1'b1);
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    repeat (2) begin
      tick();
      check("bub_valid_off", out_if.valid, 1'b0);
      check("bub_wb_off", out_if.wb_en, 1'b0);
      check("bub_mr_off", out_if.mem_r_en, 1'b0);
    end

`ifdef ID_EXE_STALL_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc_after_rst", stall_cnt, 32'd0);
    out_if.ready = 1'b0;
    drive(1'b1, 32'h99, 0, EXE_ADD, 5'd9, 1'b1, 1'b0, 1'b0, 0);
    tick();
    drive(1'b0, 0, 0, EXE_NOP, 0, 0, 0, 0, 0);
    check("sc_start", stall_cnt, 32'd0);
    repeat (5) tick();
    check("sc_five", stall_cnt, 32'd5);
    out_if.ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sc_flush_keeps", stall_cnt, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sc_rst_clears", stall_cnt, 32'd0);
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_exe_skid.md
Name: id_exe_skid

Overview:
- Decode-to-execute pipeline boundary with valid/ready handshake and a 2-entry skid buffer.
- Registers the decoded operands, the ALU command and the downstream control bits, and presents them to the execute stage (ALU) one cycle later.
- Sustains 1 op/cycle with fully registered in_ready and supports pipeline flush on branch redirect.

Parameters:
- DATA_W, WORD_LEN (32): operand/store-value width.
- DEST_W, REG_FILE_ADDR_LEN (5): destination register index width.
- CNT_W, 32: stall counter width (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all held ops (branch taken)
- in_valid  in  1  decode offers an op
- in_ready  out  1  buffer can accept; registered
- in_val1  in  DATA_W  ALU operand 1
- in_val2  in  DATA_W  ALU operand 2
- in_exe_cmd  in  execmd_t  ALU command
- in_dest  in  DEST_W  writeback register
- in_wb_en / in_mem_r_en / in_mem_w_en  in  1 each  control bits
- in_st_val  in  DATA_W  store data
- out_valid  out  1  op presented to execute
- out_ready  in  1  execute consumes
- out_val1, out_val2, out_exe_cmd, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en, out_st_val  out  as inputs  presented op
- stall_cnt  out  CNT_W  present only with feature

Behaviour:
- Fire events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main slot (drives out_*) and skid slot, each with a valid bit. States are EMPTY, ONE (main only) and FULL (main + skid).
- in_ready is the registered value of !skid_valid. It is 1 in EMPTY/ONE and 0 in FULL. It never depends combinationally on out_ready.
- out_valid = main_valid.
- EMPTY: in_fire -> ONE, main <= in.
- ONE, in_fire & out_fire: stay ONE, main <= in.
- ONE, in_fire & !out_fire: -> FULL, skid <= in.
- ONE, !in_fire & out_fire: -> EMPTY.
- FULL: in_fire impossible. On out_fire -> ONE, main <= skid, skid_valid <= 0.
- Ordering: strictly FIFO. An op never overtakes or duplicates another.
- Latency: in_fire at cycle N -> out_valid at N+1 when empty. Throughput is 1/cycle with out_ready held 1.
- out_* payload holds stable while out_valid=1 and out_ready=0.
- Bubble masking: out_wb_en, out_mem_r_en and out_mem_w_en are ANDed with out_valid, so an invalid slot can never write back or touch memory.
- Flush: next cycle both valid bits = 0 and in_ready = 1. An in_fire in the flush cycle is discarded. Flush has priority over every transition. Payload registers are not cleared by flush.
- Reset (including mid-operation): all valid bits 0, all payload registers 0, in_ready 1 on the cycle after rst deasserts. Reset has priority over flush.
- Widths: payload is passed unmodified. No arithmetic is performed.

Optional Feature:
- Macro: ID_EXE_STALL_CNT_EN.
- Defined: adds the stall_cnt port. It increments by 1 every cycle with out_valid & !out_ready, wraps at 2^CNT_W, and resets to 0 on rst (not on flush).
- Undefined: no stall_cnt port and no counter logic. Behaviour is otherwise identical.

Decomposition:
- Shared package defines: add REG_FILE_ADDR_LEN if not present, and typedef struct packed id_exe_payload_t {val1, val2, exe_cmd (execmd_t), dest, wb_en, mem_r_en, mem_w_en, st_val}.
- execmd_t and WORD_LEN are reused from the package unchanged.
- One natural sub-module, pipe_slot: a payload register plus valid bit with load/clear, instantiated twice (main, skid).

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after release, all out_* = 0.
- Streaming: out_ready=1, 8 back-to-back ops with val1=i, val2=2i, cmd=EXE_ADD -> ops emerge in order one cycle later, one per cycle, in_ready constantly 1.
- Backpressure: out_ready=0 while sending ops A(val1=0x11) and B(val1=0x22) -> FULL, in_ready=0, out_val1 holds 0x11. Raise out_ready -> 0x11 then 0x22, no loss, in_ready returns to 1.
- Flush in FULL with simultaneous in_valid: next cycle out_valid=0, in_ready=1, out_wb_en=0 and out_mem_w_en=0. The in-flight op never appears.
- Bubble control: op with wb_en=1 then idle -> out_wb_en=0 whenever out_valid=0.
- With ID_EXE_STALL_CNT_EN: hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5. Flush leaves it at 5; rst clears it to 0.
